usb_hid_supervisor: RTL and testbench
=====================================

// Module: usb_hid_supervisor
// PURPOSE
//  Power and reset sequencer for one usb_hid_host instance, clocked in the 12MHz USB domain.
//  Drives the port VBUS switch and the core's reset. Waits for enumeration (typ != 0).
//  Faults on protocol errors (conerr) or enumeration timeout, then power-cycles the port with
//  exponential backoff. Locks out after repeated failures until software requests a retry.
// PARAMETERS
//  CLK_PER_MS       12000  usbclk cycles per millisecond tick
//  OFF_MS           100    base VBUS-off time, ms
//  SETTLE_MS        50     VBUS-on time before core reset release, ms
//  ENUM_TIMEOUT_MS  2000   max time in ENUM waiting for typ != 0, ms
//  CONERR_FILT      16     consecutive conerr cycles needed to declare a fault
//  MAX_RETRIES      5      faults tolerated before LOCKOUT
//  BACKOFF_MAX_SH   3      cap on backoff shift (max off time = OFF_MS<<3)
// PORTS
//  usbclk      in   1   12MHz clock
//  usbrst_n    in   1   async active-low reset
//  retry       in   1   1-cycle pulse: manual restart (clears retry count)
//  conerr      in   1   from usb_hid_host, same clock domain
//  typ         in   2   from usb_hid_host: 0 none, 1 kbd, 2 mouse, 3 gamepad
//  report      in   1   from usb_hid_host, 1-cycle pulse per HID report
//  vbus_en     out  1   1 = port power on
//  core_rst_n  out  1   drives usb_hid_host.usbrst_n
//  state       out  3   0 OFF, 1 SETTLE, 2 ENUM, 3 ACTIVE, 4 LOCKOUT
//  retry_cnt   out  4   faults since last manual retry / successful enum, saturating
//  dev_ready   out  1   1 while in ACTIVE
//  report_cnt  out  16  reports received in ACTIVE, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: async, takes effect immediately, including mid-sequence.
//   Reset values: vbus_en=0, core_rst_n=0, state=OFF, retry_cnt=0, dev_ready=0, report_cnt=0.
//  Timing: prescaler and ms timer clear on every state entry. A state with duration N ms exits
//   exactly N*CLK_PER_MS cycles after its entry cycle. Timer width 16 bits; off time
//   OFF_MS<<sh must fit. All outputs are registered and change in the cycle of state entry.
//  OFF:     vbus_en=0, core_rst_n=0. Duration OFF_MS<<min(retry_cnt,BACKOFF_MAX_SH). -> SETTLE.
//  SETTLE:  vbus_en=1, core_rst_n=0. Duration SETTLE_MS. -> ENUM.
//  ENUM:    vbus_en=1, core_rst_n=1.
//   typ != 0 -> ACTIVE; on entry, retry_cnt is cleared to 0.
//   conerr filtered (CONERR_FILT consecutive cycles) -> FAULT.
//   Timer reaches ENUM_TIMEOUT_MS -> FAULT.
//  ACTIVE:  vbus_en=1, core_rst_n=1, dev_ready=1. Each report pulse increments report_cnt.
//   Filtered conerr -> FAULT.
//   typ becomes 0 (unplug) -> ENUM (no power cycle, no retry increment).
//   conerr fault and typ->0 in the same cycle: FAULT wins.
//  FAULT (transient, not an encoded state): retry_cnt += 1 (saturates at 15).
//   New retry_cnt >= MAX_RETRIES -> LOCKOUT; else -> OFF.
//  LOCKOUT: vbus_en=0, core_rst_n=0. Held indefinitely.
//  retry pulse, any state including LOCKOUT: retry_cnt=0, report_cnt kept, -> OFF.
//   retry has priority over every other transition in the same cycle.
//  conerr filter counter clears on any state change and whenever conerr=0.
//   conerr is ignored in OFF, SETTLE and LOCKOUT (core is held in reset there).
//  report pulses outside ACTIVE are ignored.
//  Inputs are synchronous to usbclk; no synchronisers.
// TESTING (sim with CLK_PER_MS=12, OFF_MS=4, SETTLE_MS=2, ENUM_TIMEOUT_MS=20, CONERR_FILT=4)
//  1. Release reset, raise typ=1 at cycle 100
//     -> vbus_en rises at cycle 48, core_rst_n at cycle 72, state=3 and dev_ready=1
//        one cycle after typ=1.
//  2. In ACTIVE, conerr high 3 cycles then low -> no fault.
//     conerr high 4 cycles -> state=OFF, retry_cnt=1, next OFF lasts 96 cycles.
//  3. typ held 0 -> ENUM timeouts repeat. OFF times 48, 96, 192, 384 cycles.
//     After the 5th fault: state=4, vbus_en=0.
//  4. In LOCKOUT, pulse retry -> state=OFF, retry_cnt=0, normal sequence resumes.
//  5. In ACTIVE, 3 report pulses then typ->0 -> report_cnt=3, state=ENUM,
//     retry_cnt unchanged, vbus_en stays 1.
//  6. Assert usbrst_n=0 mid-SETTLE (asynchronously, between clock edges)
//     -> vbus_en=0, core_rst_n=0, state=0 without waiting for a clock edge.

Source files
------------

// File: rtl/usb_hid_supervisor.sv
// Power/reset sequencer for one usb_hid_host port.
// Power-cycles VBUS with exponential backoff on faults, locks out after repeated failures.
module usb_hid_supervisor #(
    parameter int CLK_PER_MS      = 12000,
    parameter int OFF_MS          = 100,
    parameter int SETTLE_MS       = 50,
    parameter int ENUM_TIMEOUT_MS = 2000,
    parameter int CONERR_FILT     = 16,
    parameter int MAX_RETRIES     = 5,
    parameter int BACKOFF_MAX_SH  = 3
) (
    input  logic        usbclk,
    input  logic        usbrst_n,
    input  logic        retry,
    input  logic        conerr,
    input  logic [1:0]  typ,
    input  logic        report,
    output logic        vbus_en,
    output logic        core_rst_n,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic        dev_ready,
    output logic [15:0] report_cnt
);

    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int FW = $clog2(CONERR_FILT + 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_SETTLE  = 3'd1,
        S_ENUM    = 3'd2,
        S_ACTIVE  = 3'd3,
        S_LOCKOUT = 3'd4
    } st_t;

    st_t           st;
    st_t           nxt;
    logic [PW-1:0] pre;
    logic [15:0]   ms;
    logic [FW-1:0] flt;
    logic          go;
    logic          fault;
    logic          tick;
    logic          watch;
    logic          flt_hit;
    logic [3:0]    sh;
    logic [3:0]    rc_inc;
    logic [3:0]    nxt_rc;
    logic [15:0]   off_ms;

    assign state   = st;
    assign tick    = (pre == PW'(CLK_PER_MS - 1));
    assign watch   = (st == S_ENUM) || (st == S_ACTIVE);
    assign flt_hit = watch && conerr && (flt == FW'(CONERR_FILT - 1));
    assign sh      = (retry_cnt > 4'(BACKOFF_MAX_SH)) ? 4'(BACKOFF_MAX_SH) : retry_cnt;
    assign off_ms  = 16'(OFF_MS) << sh;
    assign rc_inc  = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

    // retry overrides everything; a fault resolves to OFF or LOCKOUT
    always_comb begin
        go     = 1'b0;
        fault  = 1'b0;
        nxt    = st;
        nxt_rc = retry_cnt;
        if (retry) begin
            go     = 1'b1;
            nxt    = S_OFF;
            nxt_rc = 4'd0;
        end else begin
            unique case (st)
                S_OFF: begin
                    if (tick && ms == off_ms - 16'd1) begin
                        go  = 1'b1;
                        nxt = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tick && ms == 16'(SETTLE_MS - 1)) begin
                        go  = 1'b1;
                        nxt = S_ENUM;
                    end
                end
                S_ENUM: begin
                    if (typ != 2'd0) begin
                        go     = 1'b1;
                        nxt    = S_ACTIVE;
                        nxt_rc = 4'd0;
                    end else if (flt_hit) begin
                        fault = 1'b1;
                    end else if (tick && ms == 16'(ENUM_TIMEOUT_MS - 1)) begin
                        fault = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (flt_hit) begin
                        fault = 1'b1;
                    end else if (typ == 2'd0) begin
                        go  = 1'b1;
                        nxt = S_ENUM;
                    end
                end
                default: ;
            endcase
        end
        if (fault) begin
            go     = 1'b1;
            nxt_rc = rc_inc;
            nxt    = (int'(rc_inc) >= MAX_RETRIES) ? S_LOCKOUT : S_OFF;
        end
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            st         <= S_OFF;
            pre        <= '0;
            ms         <= '0;
            flt        <= '0;
            retry_cnt  <= '0;
            vbus_en    <= 1'b0;
            core_rst_n <= 1'b0;
            dev_ready  <= 1'b0;
            report_cnt <= '0;
        end else begin
            retry_cnt <= nxt_rc;
            if (go) begin
                st         <= nxt;
                pre        <= '0;
                ms         <= '0;
                flt        <= '0;
                vbus_en    <= (nxt == S_SETTLE) || (nxt == S_ENUM) || (nxt == S_ACTIVE);
                core_rst_n <= (nxt == S_ENUM) || (nxt == S_ACTIVE);
                dev_ready  <= (nxt == S_ACTIVE);
            end else begin
                if (tick) begin
                    pre <= '0;
                    ms  <= ms + 16'd1;
                end else begin
                    pre <= pre + PW'(1);
                end
                flt <= (watch && conerr) ? flt + FW'(1) : '0;
            end
            if (st == S_ACTIVE && report) begin
                report_cnt <= report_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_hid_supervisor.sv
// Scoreboard bench for usb_hid_supervisor with small sim timing.
// Expected output changes are queued by stimulus and popped by a monitor.
module tb_usb_hid_supervisor;

    logic        clk;
    logic        rst_n;
    logic        retry;
    logic        conerr;
    logic [1:0]  typ;
    logic        report;
    logic        vbus_en;
    logic        core_rst_n;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic        dev_ready;
    logic [15:0] report_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic        vb;
        logic        cr;
        logic        dr;
        logic [3:0]  rc;
        logic [15:0] rp;
        string       nm;
    } exp_t;

    exp_t q[$];

    usb_hid_supervisor #(
        .CLK_PER_MS(12),
        .OFF_MS(4),
        .SETTLE_MS(2),
        .ENUM_TIMEOUT_MS(20),
        .CONERR_FILT(4),
        .MAX_RETRIES(5),
        .BACKOFF_MAX_SH(3)
    ) dut (
        .usbclk(clk),
        .usbrst_n(rst_n),
        .retry(retry),
        .conerr(conerr),
        .typ(typ),
        .report(report),
        .vbus_en(vbus_en),
        .core_rst_n(core_rst_n),
        .state(state),
        .retry_cnt(retry_cnt),
        .dev_ready(dev_ready),
        .report_cnt(report_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // posedge index since reset release: DUT edge k sets cyc to k
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic push_exp(input int c, input int s, input bit vb, input bit cr,
                            input bit dr, input int rc, input int rp, input string nm);
        exp_t e;
        e.cyc = c;
        e.st  = 3'(s);
        e.vb  = vb;
        e.cr  = cr;
        e.dr  = dr;
        e.rc  = 4'(rc);
        e.rp  = 16'(rp);
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic check_now(input string nm, input int s, input bit vb, input bit cr,
                             input bit dr, input int rc, input int rp);
        logic [25:0] got;
        logic [25:0] exp;
        got = {state, vbus_en, core_rst_n, dev_ready, retry_cnt, report_cnt};
        exp = {3'(s), vb, cr, dr, 4'(rc), 16'(rp)};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got st=%0d vb=%b cr=%b dr=%b rc=%0d rp=%0d, exp st=%0d vb=%b cr=%b dr=%b rc=%0d rp=%0d",
                     nm, state, vbus_en, core_rst_n, dev_ready, retry_cnt, report_cnt,
                     s, vb, cr, dr, rc, rp);
        end
    endtask

    task automatic check_drained(input string nm);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected events never seen, next is %s at cycle %0d",
                     nm, q.size(), q[0].nm, q[0].cyc);
        end
    endtask

    // monitor: any output change must match the head of the queue
    initial begin
        logic [25:0] prev;
        logic [25:0] cur;
        logic [25:0] want;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = '0;
            end else begin
                cur = {state, vbus_en, core_rst_n, dev_ready, retry_cnt, report_cnt};
                if (cur !== prev) begin
                    prev = cur;
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_change: cycle %0d st=%0d vb=%b cr=%b dr=%b rc=%0d rp=%0d, no change required",
                                 cyc, state, vbus_en, core_rst_n, dev_ready, retry_cnt, report_cnt);
                    end else begin
                        e = q.pop_front();
                        want = {e.st, e.vb, e.cr, e.dr, e.rc, e.rp};
                        if (cyc != e.cyc || cur !== want) begin
                            fails++;
                            $display("FAIL %s: got cycle %0d st=%0d vb=%b cr=%b dr=%b rc=%0d rp=%0d, exp cycle %0d st=%0d vb=%b cr=%b dr=%b rc=%0d rp=%0d",
                                     e.nm, cyc, state, vbus_en, core_rst_n, dev_ready, retry_cnt, report_cnt,
                                     e.cyc, e.st, e.vb, e.cr, e.dr, e.rc, e.rp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        retry  = 1'b0;
        conerr = 1'b0;
        typ    = 2'd0;
        report = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_values", 0, 0, 0, 0, 0, 0);

        // OFF 48, SETTLE 24, ENUM timeout 240 cycles; backoff 96/192/384/384
        push_exp(48,   1, 1, 0, 0, 0, 0, "p1_settle");
        push_exp(72,   2, 1, 1, 0, 0, 0, "p1_enum");
        push_exp(101,  3, 1, 1, 1, 0, 0, "p1_active");
        push_exp(124,  0, 0, 0, 0, 1, 0, "p2_conerr_fault");
        push_exp(220,  1, 1, 0, 0, 1, 0, "p2_off_96");
        push_exp(244,  2, 1, 1, 0, 1, 0, "p2_enum");
        push_exp(484,  0, 0, 0, 0, 2, 0, "p3_timeout1");
        push_exp(676,  1, 1, 0, 0, 2, 0, "p3_off_192");
        push_exp(700,  2, 1, 1, 0, 2, 0, "p3_enum2");
        push_exp(940,  0, 0, 0, 0, 3, 0, "p3_timeout2");
        push_exp(1324, 1, 1, 0, 0, 3, 0, "p3_off_384");
        push_exp(1348, 2, 1, 1, 0, 3, 0, "p3_enum3");
        push_exp(1588, 0, 0, 0, 0, 4, 0, "p3_timeout3");
        push_exp(1972, 1, 1, 0, 0, 4, 0, "p3_off_384_cap");
        push_exp(1996, 2, 1, 1, 0, 4, 0, "p3_enum4");
        push_exp(2236, 4, 0, 0, 0, 5, 0, "p3_lockout");
        push_exp(2301, 0, 0, 0, 0, 0, 0, "p4_retry_off");
        push_exp(2349, 1, 1, 0, 0, 0, 0, "p4_settle");
        push_exp(2373, 2, 1, 1, 0, 0, 0, "p4_enum");
        push_exp(2381, 3, 1, 1, 1, 0, 0, "p4_active");
        push_exp(2391, 3, 1, 1, 1, 0, 1, "p5_report1");
        push_exp(2393, 3, 1, 1, 1, 0, 2, "p5_report2");
        push_exp(2395, 3, 1, 1, 1, 0, 3, "p5_report3");
        push_exp(2401, 2, 1, 1, 0, 0, 3, "p5_unplug_enum");
        push_exp(2411, 3, 1, 1, 1, 0, 3, "p5_replug");
        push_exp(2424, 0, 0, 0, 0, 1, 3, "p5_fault_beats_unplug");
        push_exp(2520, 1, 1, 0, 0, 1, 3, "p5_settle");

        rst_n = 1'b1;
        wait_cyc(100);  typ = 2'd1;
        wait_cyc(110);  conerr = 1'b1;
        wait_cyc(113);  conerr = 1'b0;
        wait_cyc(120);  conerr = 1'b1;
        wait_cyc(124);  conerr = 1'b0; typ = 2'd0;
        wait_cyc(2300); retry = 1'b1;
        wait_cyc(2301); retry = 1'b0;
        wait_cyc(2375); report = 1'b1;
        wait_cyc(2376); report = 1'b0;
        wait_cyc(2380); typ = 2'd1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(2390 + 2 * i); report = 1'b1;
            wait_cyc(2391 + 2 * i); report = 1'b0;
        end
        wait_cyc(2400); typ = 2'd0;
        wait_cyc(2410); typ = 2'd1;
        wait_cyc(2420); conerr = 1'b1;
        wait_cyc(2423); typ = 2'd0;
        wait_cyc(2424); conerr = 1'b0;

        // asynchronous reset in the middle of SETTLE, between clock edges
        wait_cyc(2530);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset_mid_settle", 0, 0, 0, 0, 0, 0);
        check_drained("phase1_to_5_events");

        repeat (2) @(negedge clk);
        push_exp(48,  1, 1, 0, 0, 0, 0, "p7_settle");
        push_exp(72,  2, 1, 1, 0, 0, 0, "p7_enum");
        push_exp(81,  0, 0, 0, 0, 0, 0, "p7_retry_beats_typ");
        push_exp(129, 1, 1, 0, 0, 0, 0, "p7_settle2");
        push_exp(153, 2, 1, 1, 0, 0, 0, "p7_enum2");
        push_exp(154, 3, 1, 1, 1, 0, 0, "p7_active");
        rst_n = 1'b1;
        wait_cyc(80);  typ = 2'd1; retry = 1'b1;
        wait_cyc(81);  retry = 1'b0;
        wait_cyc(170);
        check_now("final_active", 3, 1, 1, 1, 0, 0);
        check_drained("phase7_events");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
